// File: rtl/adc_frame_scheduler.sv
// adc_frame_scheduler
// Serialises one snapshot of all ADC channel results per sample tick onto a
// single AXI-Stream master. Enabled channels go out in ascending index order,
// with tlast on the final beat. Ticks that arrive while a frame is still
// draining are dropped and counted as overruns.
//
// Optional build macro: ADC_FRAME_HEADER_EN
//   When defined, every frame starts with one header beat that carries
//   {mask, frame_cnt} before the channel beats.
//
// Ports:
//   CLK100MHz      - sole clock
//   ARESETN        - asynchronous active-low reset
//   sample_tick    - one-cycle pulse; ch_data holds new results
//   ch_data        - flattened samples, channel k at [k*DATA_W +: DATA_W]
//   ch_enable      - per-channel inclusion mask, sampled at the tick
//   clear_overrun  - synchronous clear of overrun_cnt / overrun_flag
//   m_axis_*       - AXI-Stream master (tdata, tkeep, tvalid, tready, tlast)
//   busy           - frame in progress
//   frame_cnt      - completed frames, wraps
//   overrun_cnt    - dropped ticks, saturates
//   overrun_flag   - sticky, set on first dropped tick
module adc_frame_scheduler #(
  parameter int NUM_CH     = 16,
  parameter int DATA_W     = 32,
  parameter int AXIS_BYTES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                     CLK100MHz,
  input  logic                     ARESETN,
  input  logic                     sample_tick,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic                     clear_overrun,
  output logic [AXIS_BYTES*8-1:0]  m_axis_tdata,
  output logic [AXIS_BYTES-1:0]    m_axis_tkeep,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     busy,
  output logic [CNT_W-1:0]         frame_cnt,
  output logic [CNT_W-1:0]         overrun_cnt,
  output logic                     overrun_flag
);

  localparam int AXIS_W = AXIS_BYTES * 8;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_SEND} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_snap [NUM_CH];
  // Channels still to be sent after the beat currently presented.
  logic [NUM_CH-1:0]   r_rem;
  logic [AXIS_W-1:0]   r_tdata;
  logic                r_tvalid;
  logic                r_tlast;
  logic [CNT_W-1:0]    r_frame_cnt;
  logic [CNT_W-1:0]    r_ovr_cnt;
  logic                r_ovr_flag;

  logic                w_hs;
  logic                w_last_hs;
  logic                w_start;
  logic                w_overrun;
  logic [IDX_W-1:0]    w_first_idx;
  logic [NUM_CH-1:0]   w_first_rest;
  logic [IDX_W-1:0]    w_next_idx;
  logic [NUM_CH-1:0]   w_next_rest;

  // Priority encoder: index of the lowest set bit (0 if none).
  function automatic logic [IDX_W-1:0] f_lowest(input logic [NUM_CH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign w_hs      = r_tvalid & m_axis_tready;
  assign w_last_hs = w_hs & r_tlast & (r_state == ST_SEND);
  // A tick on the closing handshake chains straight into the next frame.
  assign w_start   = sample_tick & (ch_enable != '0) &
                     ((r_state == ST_IDLE) | w_last_hs);
  assign w_overrun = sample_tick & (r_state != ST_IDLE) & ~w_last_hs;

  assign w_first_idx  = f_lowest(ch_enable);
  assign w_first_rest = ch_enable & ~(NUM_CH'(1'b1) << w_first_idx);
  assign w_next_idx   = f_lowest(r_rem);
  assign w_next_rest  = r_rem & ~(NUM_CH'(1'b1) << w_next_idx);

`ifdef ADC_FRAME_HEADER_EN
  localparam int HDR_W = CNT_W + NUM_CH;
  logic [CNT_W-1:0]  w_hdr_cnt;
  logic [HDR_W-1:0]  w_hdr_full;
  logic [AXIS_W-1:0] w_hdr_word;
  // On a chained start the count has just advanced for the previous frame.
  assign w_hdr_cnt  = w_last_hs ? (r_frame_cnt + CNT_W'(1)) : r_frame_cnt;
  assign w_hdr_full = {ch_enable, w_hdr_cnt};
  generate
    if (HDR_W >= AXIS_W) begin : g_hdr_trunc
      assign w_hdr_word = w_hdr_full[AXIS_W-1:0];
    end else begin : g_hdr_ext
      assign w_hdr_word = {{(AXIS_W-HDR_W){1'b0}}, w_hdr_full};
    end
  endgenerate
`endif

  // Frame FSM, snapshot capture, stream outputs and counters.
  always_ff @(posedge CLK100MHz or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_frame_cnt <= '0;
      r_ovr_cnt   <= '0;
      r_ovr_flag  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) r_snap[k] <= '0;
    end else begin
      if (w_start) begin
        for (int k = 0; k < NUM_CH; k++) r_snap[k] <= ch_data[k*DATA_W +: DATA_W];
      end

      if (w_last_hs) r_frame_cnt <= r_frame_cnt + CNT_W'(1);

      if (clear_overrun) begin
        r_ovr_cnt  <= '0;
        r_ovr_flag <= 1'b0;
      end else if (w_overrun) begin
        r_ovr_flag <= 1'b1;
        if (r_ovr_cnt != '1) r_ovr_cnt <= r_ovr_cnt + CNT_W'(1);
      end

      if (w_start) begin
        r_tvalid <= 1'b1;
`ifdef ADC_FRAME_HEADER_EN
        r_state  <= ST_HEADER;
        r_tdata  <= w_hdr_word;
        r_tlast  <= 1'b0;
        r_rem    <= ch_enable;
`else
        r_state  <= ST_SEND;
        r_tdata  <= AXIS_W'(ch_data[w_first_idx*DATA_W +: DATA_W]);
        r_tlast  <= (w_first_rest == '0);
        r_rem    <= w_first_rest;
`endif
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
          end
          ST_HEADER: begin
            if (w_hs) begin
              r_state <= ST_SEND;
              r_tdata <= AXIS_W'(r_snap[w_next_idx]);
              r_tlast <= (w_next_rest == '0);
              r_rem   <= w_next_rest;
            end
          end
          ST_SEND: begin
            if (w_hs) begin
              if (r_tlast) begin
                r_state  <= ST_IDLE;
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
              end else begin
                r_tdata <= AXIS_W'(r_snap[w_next_idx]);
                r_tlast <= (w_next_rest == '0);
                r_rem   <= w_next_rest;
              end
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tkeep  = {AXIS_BYTES{r_tvalid}};
  assign busy          = (r_state != ST_IDLE);
  assign frame_cnt     = r_frame_cnt;
  assign overrun_cnt   = r_ovr_cnt;
  assign overrun_flag  = r_ovr_flag;

endmodule
